// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: loader state
// encoding, the NOOP word and the opcodes used by test programs.
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [31:0] NOOP = 32'h0000_0000;

  localparam logic [5:0] OP_LI   = 6'b111001;
  localparam logic [5:0] OP_LUI  = 6'b111010;
  localparam logic [5:0] OP_ADD  = 6'b010010;
  localparam logic [5:0] OP_ADDI = 6'b110010;
  localparam logic [5:0] OP_SWI  = 6'b111100;
  localparam logic [5:0] OP_LWI  = 6'b111011;
  localparam logic [5:0] OP_BNEZ = 6'b100001;
  localparam logic [5:0] OP_J    = 6'b000001;

  // Assemble an immediate-format word: opcode | rd | rs | imm16.
  function automatic logic [31:0] mk_itype(input logic [5:0]  op,
                                           input logic [4:0]  rd,
                                           input logic [4:0]  rs,
                                           input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

endpackage

// File: rtl/imem_addr_check.sv
// Fetch address translation: PC to word index plus a range/alignment error.
// In byte mode the two low PC bits must be zero and the index is PC >> 2.
// Any PC whose word value reaches DEPTH (including stray upper bits) is bad.
module imem_addr_check #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BYTE_ADDR  = 0
) (
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] index,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] word;
  logic                  misaligned;

  generate
    if (BYTE_ADDR != 0) begin : g_byte
      assign word       = {2'b00, pc[DATA_WIDTH-1:2]};
      assign misaligned = |pc[1:0];
    end else begin : g_word
      assign word       = pc;
      assign misaligned = 1'b0;
    end
  endgenerate

  // Comparing the full-width word catches both index >= DEPTH and any
  // upper bits that would otherwise be truncated away by the index slice.
  assign err   = misaligned | (word >= DATA_WIDTH'(DEPTH));
  assign index = word[ADDR_WIDTH-1:0];

endmodule

// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory. After reset the array is cleared one
// word per cycle, then a host loads program words until LoadDone; in RUN the
// core fetches through a registered, stallable port with one cycle latency.
//
//   state | meaning
//   CLEAR | counter writes zero to every entry, loader inputs ignored
//   LOAD  | host writes words, LoadDone moves to RUN
//   RUN   | fetches served, LoadStart returns to LOAD without clearing
module imem_loadable
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BYTE_ADDR  = 0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] PC,
  input  logic                  FetchEn,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic                  InstrValid,
  output logic                  AddrErr,
  input  logic                  LoadStart,
  input  logic                  LoadValid,
  input  logic [ADDR_WIDTH-1:0] LoadAddr,
  input  logic [DATA_WIDTH-1:0] LoadData,
  input  logic                  LoadDone,
  output logic                  Ready
);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clr_last;
  logic                  clr_we;
  logic                  load_we;
  logic                  load_in_range;
  logic [ADDR_WIDTH:0]   load_addr_ext;
  logic                  fetch_go;
  logic                  leave_run;
  logic [ADDR_WIDTH-1:0] fetch_idx;
  logic                  fetch_err;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  imem_addr_check #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYTE_ADDR  (BYTE_ADDR)
  ) u_addr_check (
    .pc    (PC),
    .index (fetch_idx),
    .err   (fetch_err)
  );

  assign clr_last = (clr_cnt == ADDR_WIDTH'(DEPTH - 1));

  // One extra bit so the range test stays meaningful when DEPTH is a power
  // of two (then every LoadAddr is in range) and when it is not.
  assign load_addr_ext = {1'b0, LoadAddr};
  assign load_in_range = (load_addr_ext < (ADDR_WIDTH + 1)'(DEPTH));

  // Loader state register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; LoadStart is only honoured from RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_last) state_nxt = LOAD;
      LOAD:    if (LoadDone) state_nxt = RUN;
      RUN:     if (LoadStart) state_nxt = LOAD;
      default: state_nxt = CLEAR;
    endcase
  end

  // Per-state strobes: array write source, fetch enable and Ready.
  always_comb begin
    clr_we    = 1'b0;
    load_we   = 1'b0;
    fetch_go  = 1'b0;
    leave_run = 1'b0;
    Ready     = 1'b0;
    case (state)
      CLEAR: clr_we = 1'b1;
      LOAD:  load_we = LoadValid & load_in_range;
      RUN: begin
        Ready     = 1'b1;
        leave_run = LoadStart;
        fetch_go  = FetchEn & ~LoadStart;
      end
      default: ;
    endcase
  end

  // Clear counter walks 0..DEPTH-1 and parks at zero once CLEAR is done.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      clr_cnt <= '0;
    end else if (clr_we) begin
      clr_cnt <= clr_last ? '0 : clr_cnt + ADDR_WIDTH'(1);
    end
  end

  // Instruction array: single write port, source chosen by state.
  always_ff @(posedge Clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (load_we) begin
      mem[LoadAddr] <= LoadData;
    end
  end

  // Registered fetch port; leaving RUN wipes it, stalls hold it.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Instruction <= DATA_WIDTH'(NOOP);
      InstrValid  <= 1'b0;
      AddrErr     <= 1'b0;
    end else if (leave_run) begin
      Instruction <= DATA_WIDTH'(NOOP);
      InstrValid  <= 1'b0;
      AddrErr     <= 1'b0;
    end else if (fetch_go) begin
      Instruction <= fetch_err ? DATA_WIDTH'(NOOP) : mem[fetch_idx];
      InstrValid  <= 1'b1;
      AddrErr     <= fetch_err;
    end
  end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, run-time loadable instruction memory. It succeeds the hard-coded instruction ROM and sits between the PC register and the decode stage of the EC413 MIPS-style CPU. A loader state machine clears the array after reset and accepts program words from a testbench or host port. The core then fetches through a registered, stallable read port with one cycle of latency. Out-of-range and misaligned fetches return NOOP (all zeros) and raise a flag.

## Interface
- DATA_WIDTH, 32: instruction and data width in bits.
- DEPTH, 64: number of instruction words; any value ≥ 2, not necessarily a power of two.
- ADDR_WIDTH, $clog2(DEPTH): width of the internal word index.
- BYTE_ADDR, 0: 0 means PC is a word index (PC = 1 is the next instruction); 1 means PC is a byte address, word index = PC >> 2.
- Clk  input  1  clock; all state changes on the rising edge.
- Rst  input  1  reset, asynchronous, active-high.
- PC  input  DATA_WIDTH  fetch address.
- FetchEn  input  1  request a fetch this cycle; low = stall.
- Instruction  output  DATA_WIDTH  registered instruction.
- InstrValid  output  1  Instruction holds the result of a completed fetch.
- AddrErr  output  1  the last completed fetch was out of range or misaligned.
- LoadStart  input  1  enter LOAD state; in RUN this triggers a reprogram.
- LoadValid  input  1  write LoadData to word LoadAddr.
- LoadAddr  input  ADDR_WIDTH  word index of the load write.
- LoadData  input  DATA_WIDTH  instruction word to write.
- LoadDone  input  1  finish loading and enter RUN.
- Ready  output  1  high in RUN only.

## Operation
- States:
  - CLEAR: a word counter writes 0 to entries 0..DEPTH-1, one per cycle.
    - After the last entry, go to LOAD.
    - LoadStart, LoadValid and LoadDone are ignored in CLEAR.
  - LOAD: each cycle with LoadValid high writes the array.
    - LoadAddr ≥ DEPTH is dropped silently.
    - LoadDone goes to RUN. If LoadValid and LoadDone are high together, the write is performed first, then the state moves to RUN.
    - LoadStart in LOAD has no effect.
  - RUN: fetches are served.
    - LoadStart goes to LOAD without clearing the array, so a partial patch is possible.
    - LoadValid in RUN is ignored.
- Fetch, taken only in RUN with FetchEn high:
  - The word index is PC (BYTE_ADDR=0) or PC[DATA_WIDTH-1:2] (BYTE_ADDR=1).
  - Error condition: index ≥ DEPTH, any upper PC bit set beyond the index range, or PC[1:0] ≠ 0 when BYTE_ADDR=1.
  - Error fetch: Instruction ← 0, AddrErr ← 1.
  - Good fetch: Instruction ← mem[index], AddrErr ← 0.
  - InstrValid ← 1 on every fetch, good or error.
- Stall: FetchEn low in RUN holds Instruction, InstrValid and AddrErr unchanged.
- Leaving RUN (LoadStart): on the next edge InstrValid ← 0, Instruction ← 0, AddrErr ← 0.
- The array is DEPTH × DATA_WIDTH of plain registers.
  - At most one write per cycle: the clear write in CLEAR, the load write in LOAD.
  - Read and write never happen in the same state, so there is no read-during-write hazard.

## Timing
- Reset (async assert, any state, including mid-CLEAR or mid-LOAD):
  - State = CLEAR, clear counter = 0.
  - Instruction = 0, InstrValid = 0, AddrErr = 0, Ready = 0.
  - Array contents are undefined until CLEAR completes.
- CLEAR lasts exactly DEPTH cycles after reset deassertion.
- Ready rises the cycle after LoadDone is sampled in LOAD.
- Fetch latency is 1 cycle: PC sampled at edge N gives Instruction valid after edge N, usable in cycle N+1.
- A PC change during a stall has no effect until FetchEn is high.
- Back-to-back fetches give one instruction per cycle.
- A load write at edge N is visible to a fetch sampled at edge N+2 or later, i.e. after LoadDone and the RUN entry.

## Structure
- Shared package imem_pkg:
  - State encoding: CLEAR=2'd0, LOAD=2'd1, RUN=2'd2.
  - NOOP constant = 0.
  - Opcode constants used by test programs (LI 6'b111001, LUI 6'b111010, ADD 6'b010010, ADDI 6'b110010, SWI 6'b111100, LWI 6'b111011, BNEZ 6'b100001, J 6'b000001).
- One sub-module, imem_addr_check: combinational PC → index plus error flag, parametrised by DATA_WIDTH, DEPTH and BYTE_ADDR.
- The FSM, clear counter, array and output register live in the top level.

## Test plan
- Reset then clear (DEPTH=16): Ready stays 0 for 16 cycles. After LoadDone, fetching PC=3 gives Instruction=0, InstrValid=1, AddrErr=0.
- Load and fetch:
  - Load words 0..2 = 32'hE400FFFF, 32'hE800FFFF, 32'h48601000, then LoadDone.
  - Fetch PC=0,1,2 back-to-back: outputs appear one cycle later, in order, one per cycle.
- Stall and bounds:
  - Fetch PC=1, then drop FetchEn for 3 cycles while PC changes to 2: Instruction stays 32'hE800FFFF.
  - Then fetch PC=16 (DEPTH=16): Instruction=0, AddrErr=1.
- Byte mode (BYTE_ADDR=1):
  - PC=8 returns word 2.
  - PC=6 returns 0 with AddrErr=1.
  - PC=32'h0001_0000 returns 0 with AddrErr=1.
- Reprogram: LoadStart in RUN.
  - Next cycle: InstrValid=0, Ready=0.
  - Patch word 1 = 32'hC8000001 with LoadValid+LoadDone in the same cycle.
  - Fetching PC=1 returns 32'hC8000001; word 0 keeps its old value.
- Async reset mid-LOAD (after 2 writes): outputs go to 0 immediately. CLEAR repeats for DEPTH cycles, and both previously written words read 0 afterwards.
